kyber_hpm_sequencer: RTL and testbench
======================================

Name: kyber_hpm_sequencer

Overview:
- Streaming front-end and controller for the single-PE Kyber half polynomial multiplier (KyberHPM1PE); sits directly upstream and downstream of it.
- Accepts polynomial A (POLY domain, natural order) and polynomial B (NTT domain, natural order) over a valid/ready stream and buffers each one.
- Drives the PE command sequence: load A, load B with reordering, FNTT, PWM2, INTT, read.
- Captures the PE's interleaved output into natural order and streams it out with valid/ready.

Parameters:
- N, 256, coefficients per polynomial.
- CW, 12, coefficient width.
- DONE_MASK, 2, cycles after a start pulse during which pe_done is ignored.
- RD_LAT, 3, cycles from the read_a pulse to the first valid pe_dout word.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input coefficient valid.
- s_ready  out  1  input coefficient accepted when s_valid&&s_ready.
- s_data  in  CW  input coefficient.
- m_valid  out  1  result coefficient valid.
- m_ready  in  1  downstream accept.
- m_data  out  CW  result coefficient, natural order.
- m_last  out  1  high with coefficient N-1.
- busy  out  1  high in every state except FILL_A.
- load_a_f, load_a_i, load_b_f, load_b_i, read_a, read_b, start_ab, start_fntt, start_pwm2, start_intt  out  1 each  PE command pulses.
- pe_din  out  CW  PE data input.
- pe_dout  in  CW  PE data output.
- pe_done  in  1  PE operation done.

Behaviour:
- Single N x CW buffer (register array or inferred RAM, 1 write + 1 read port), reused for A, B and the result.
- Reset: every output is 0 and the state goes to FILL_A. Reset mid-operation aborts the sequence with no further PE pulses. Buffer contents are don't-care.
- load_a_i, load_b_f, read_b and start_ab are tied to 0.
- FILL_A:
  - s_ready=1; each accepted word is written at addr=cnt, then cnt++.
  - On the Nth accept, go to BURST_A.
- BURST_A:
  - Cycle 0: load_a_f=1 for one cycle.
  - Cycles 1..N: pe_din = buf[0..N-1], contiguous, no gaps.
  - pe_din=0 whenever no burst is active.
  - Then 2 idle cycles (GAP_A), then FILL_B.
- FILL_B: same as FILL_A, storing B in natural order.
- BURST_B:
  - load_b_i pulse, then N contiguous words.
  - For group k=0..N/4-1 the read order is buf[4k], buf[4k+2], buf[4k+1], buf[4k+3].
  - Then 2 idle cycles.
- OP states FNTT, PWM2, INTT, in that order. Each state:
  - one-cycle start pulse;
  - pe_done is ignored for the next DONE_MASK cycles;
  - then wait for pe_done==1; the first such cycle advances to the next state.
  - pe_done already high when the mask expires advances immediately.
  - No timeout.
- After INTT: 2 idle cycles, then a one-cycle read_a pulse at cycle R.
- READ:
  - pe_dout is sampled on cycles R+RD_LAT .. R+RD_LAT+N-1.
  - Sample j is written to index (j even ? j/2 : N/2 + (j-1)/2), i.e. the PE order is 0,128,1,129,...
  - Sampling cannot stall.
- DRAIN:
  - m_valid=1 with m_data = buf[i], i=0..N-1 in order.
  - Outputs hold stable while m_valid&&!m_ready.
  - m_last=1 for i=N-1.
  - Handshake on i=N-1 returns to FILL_A; s_ready goes high the next cycle.
- s_ready=0 in all states except FILL_A/FILL_B. m_valid=0 except in DRAIN.
- Simultaneous events: s_valid in a non-fill state is held off, not dropped. A start pulse is never issued in the same cycle as a load or read pulse.

Test Plan:
- Full run against the real KyberHPM1PE using KYBER_DIN0 / KYBER_DIN1_MFNTT streamed with s_valid=1 constantly -> all 256 m_data words equal KYBER_DOUT and m_last is seen exactly once at index 255.
- PE-side monitor with B = 0..255 -> load_b_i pulse followed by pe_din sequence 0,2,1,3,4,6,5,7,...,252,254,253,255 with no gaps; A burst reads 0..255 right after load_a_f.
- Random s_valid gaps and m_ready backpressure (~50%) -> same 256 results. m_data stays stable while stalled and s_ready=0 outside the fill states.
- PE stub holding pe_done=1 continuously -> each OP state lasts exactly 1+DONE_MASK+1 cycles; start_fntt, start_pwm2, start_intt each pulse once, in order.
- Assert reset for 1 cycle while in INTT -> next cycle all PE commands are 0, busy=0, s_ready=1. A following full run still matches KYBER_DOUT.
- Back-to-back: second polynomial pair offered during DRAIN -> no s_ready until the last handshake, then the second result is correct.

Source files
------------

// File: rtl/kyber_hpm_sequencer.sv
// Stream front-end and command sequencer for the single-PE Kyber half polynomial multiplier.
// Buffers A and B, bursts them into the PE, runs FNTT/PWM2/INTT, then re-orders and drains the result.
module kyber_hpm_sequencer #(
   parameter int N         = 256,
   parameter int CW        = 12,
   parameter int DONE_MASK = 2,
   parameter int RD_LAT    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [CW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [CW-1:0] m_data,
   output logic          m_last,
   output logic          busy,
   output logic          load_a_f,
   output logic          load_a_i,
   output logic          load_b_f,
   output logic          load_b_i,
   output logic          read_a,
   output logic          read_b,
   output logic          start_ab,
   output logic          start_fntt,
   output logic          start_pwm2,
   output logic          start_intt,
   output logic [CW-1:0] pe_din,
   input  logic [CW-1:0] pe_dout,
   input  logic          pe_done
);

   localparam int AW    = $clog2(N);
   localparam int CNT_W = $clog2(N + RD_LAT + 1);

   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_N      = CNT_W'(N);
   localparam logic [CNT_W-1:0] C_NM1    = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] C_NM2    = CNT_W'(N - 2);
   localparam logic [CNT_W-1:0] C_ARM    = CNT_W'(DONE_MASK + 1);
   localparam logic [CNT_W-1:0] C_RD_LAT = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] C_RD_END = CNT_W'(RD_LAT + N - 1);

   typedef enum logic [3:0] {
      FILL_A, BURST_A, GAP_A, FILL_B, BURST_B, GAP_B,
      OP_FNTT, OP_PWM2, OP_INTT, GAP_R, READ, DRAIN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CW-1:0]    mem [N];

   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    wr_addr;
   logic [CW-1:0]    rd_data;
   logic [CW-1:0]    wr_data;
   logic             wr_en;
   logic             s_fire;
   logic             m_fire;
   logic [CNT_W-1:0] smp;
   logic [AW-1:0]    smp_idx;

   assign s_ready  = (state == FILL_A) || (state == FILL_B);
   assign busy     = (state != FILL_A);
   assign load_a_i = 1'b0;
   assign load_b_f = 1'b0;
   assign read_b   = 1'b0;
   assign start_ab = 1'b0;

   assign s_fire  = s_valid && s_ready;
   assign m_fire  = m_valid && m_ready;

   // PE emits 0,N/2,1,N/2+1,...: sample j lands at {j[0], j[AW-1:1]}.
   assign smp     = cnt - C_RD_LAT;
   assign smp_idx = {smp[0], smp[AW-1:1]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rd_addr = '0;
      unique case (state)
         BURST_A: rd_addr = cnt[AW-1:0];
         BURST_B: rd_addr = {cnt[AW-1:2], cnt[0], cnt[1]};
         DRAIN:   rd_addr = cnt[AW-1:0] + AW'(1);
         default: rd_addr = '0;
      endcase
   end

   assign wr_en   = s_fire || ((state == READ) && (cnt >= C_RD_LAT));
   assign wr_addr = s_fire ? cnt[AW-1:0] : smp_idx;
   assign wr_data = s_fire ? s_data : pe_dout;
   assign rd_data = mem[rd_addr];

   // NOTE: the coefficient buffer has no reset; its contents are always overwritten before being read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FILL_A;
         cnt        <= '0;
         load_a_f   <= 1'b0;
         load_b_i   <= 1'b0;
         read_a     <= 1'b0;
         start_fntt <= 1'b0;
         start_pwm2 <= 1'b0;
         start_intt <= 1'b0;
         pe_din     <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
      end else begin
         load_a_f   <= 1'b0;
         load_b_i   <= 1'b0;
         read_a     <= 1'b0;
         start_fntt <= 1'b0;
         start_pwm2 <= 1'b0;
         start_intt <= 1'b0;
         unique case (state)
            FILL_A, FILL_B: begin
               if (s_fire) begin
                  if (cnt == C_NM1) begin
                     cnt <= '0;
                     if (state == FILL_A) begin
                        state    <= BURST_A;
                        load_a_f <= 1'b1;
                     end else begin
                        state    <= BURST_B;
                        load_b_i <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + C_ONE;
                  end
               end
            end
            BURST_A, BURST_B: begin
               // cycle 0 carries the load pulse; buffer word k appears on cycle k+1
               if (cnt == C_N) begin
                  pe_din <= '0;
                  cnt    <= '0;
                  state  <= (state == BURST_A) ? GAP_A : GAP_B;
               end else begin
                  pe_din <= rd_data;
                  cnt    <= cnt + C_ONE;
               end
            end
            GAP_A, GAP_B, GAP_R: begin
               if (cnt == C_ONE) begin
                  cnt <= '0;
                  if (state == GAP_A) begin
                     state <= FILL_B;
                  end else if (state == GAP_B) begin
                     state      <= OP_FNTT;
                     start_fntt <= 1'b1;
                  end else begin
                     state  <= READ;
                     read_a <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            OP_FNTT, OP_PWM2, OP_INTT: begin
               // cnt saturates once the done mask has expired
               if (cnt == C_ARM) begin
                  if (pe_done) begin
                     cnt <= '0;
                     if (state == OP_FNTT) begin
                        state      <= OP_PWM2;
                        start_pwm2 <= 1'b1;
                     end else if (state == OP_PWM2) begin
                        state      <= OP_INTT;
                        start_intt <= 1'b1;
                     end else begin
                        state <= GAP_R;
                     end
                  end
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            READ: begin
               if (cnt == C_RD_END) begin
                  state   <= DRAIN;
                  cnt     <= '0;
                  m_valid <= 1'b1;
                  m_data  <= rd_data;
                  m_last  <= 1'b0;
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            DRAIN: begin
               if (m_fire) begin
                  if (cnt == C_NM1) begin
                     state   <= FILL_A;
                     cnt     <= '0;
                     m_valid <= 1'b0;
                     m_data  <= '0;
                     m_last  <= 1'b0;
                  end else begin
                     cnt    <= cnt + C_ONE;
                     m_data <= rd_data;
                     m_last <= (cnt == C_NM2);
                  end
               end
            end
            default: state <= FILL_A;
         endcase
      end
   end

endmodule

// File: tb/tb_kyber_hpm_sequencer.sv
// Directed bench for kyber_hpm_sequencer with a PE stub that captures bursts and replays interleaved results.
// Result model: result[i] = A[i] ^ B[i], with B recovered from the reordered burst.
module tb_kyber_hpm_sequencer;

   localparam int N         = 256;
   localparam int CW        = 12;
   localparam int DONE_MASK = 2;
   localparam int RD_LAT    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [CW-1:0] s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [CW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          load_a_f, load_a_i, load_b_f, load_b_i, read_a, read_b;
   logic          start_ab, start_fntt, start_pwm2, start_intt;
   logic [CW-1:0] pe_din;
   logic [CW-1:0] pe_dout = '0;
   logic          pe_done = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [CW-1:0] va [2][N];
   logic [CW-1:0] vb [2][N];
   logic [CW-1:0] cap_a [N];
   logic [CW-1:0] cap_b [N];
   logic [CW-1:0] raw_b [N];

   int cyc = 0, a_ph = -1, b_ph = -1, r_ph = -1, op_ph = -1, done_mode = 0;
   int n_load_a = 0, n_load_b = 0, n_fntt = 0, n_pwm2 = 0, n_intt = 0, n_read = 0;
   int t_fntt = 0, t_pwm2 = 0, t_intt = 0, t_read = 0;
   int viol = 0, gap_viol = 0;

   kyber_hpm_sequencer #(.N(N), .CW(CW), .DONE_MASK(DONE_MASK), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy),
      .load_a_f(load_a_f), .load_a_i(load_a_i), .load_b_f(load_b_f), .load_b_i(load_b_i),
      .read_a(read_a), .read_b(read_b), .start_ab(start_ab),
      .start_fntt(start_fntt), .start_pwm2(start_pwm2), .start_intt(start_intt),
      .pe_din(pe_din), .pe_dout(pe_dout), .pe_done(pe_done)
   );

   always #5 clk = ~clk;

   function automatic int perm(input int k);
      return (k & ~3) | ((k & 1) << 1) | ((k >> 1) & 1);
   endfunction

   // PE stub and protocol monitor, evaluated on the falling edge
   always @(negedge clk) begin
      int j, i;
      cyc++;
      if (reset) begin
         a_ph = -1; b_ph = -1; r_ph = -1; op_ph = -1;
         pe_dout = '0;
      end else begin
         if (a_ph >= 0) begin
            a_ph++;
            if (a_ph <= N) cap_a[a_ph-1] = pe_din;
            else begin
               if (pe_din !== '0) gap_viol++;
               a_ph = -1;
            end
         end
         if (b_ph >= 0) begin
            b_ph++;
            if (b_ph <= N) begin
               raw_b[b_ph-1] = pe_din;
               cap_b[perm(b_ph-1)] = pe_din;
            end else begin
               if (pe_din !== '0) gap_viol++;
               b_ph = -1;
            end
         end
         if (load_a_f) begin if (pe_din !== '0) gap_viol++; a_ph = 0; n_load_a++; end
         if (load_b_i) begin if (pe_din !== '0) gap_viol++; b_ph = 0; n_load_b++; end
         if (op_ph >= 0) op_ph++;
         if (start_fntt) begin op_ph = 0; n_fntt++; t_fntt = cyc; end
         if (start_pwm2) begin op_ph = 0; n_pwm2++; t_pwm2 = cyc; end
         if (start_intt) begin op_ph = 0; n_intt++; t_intt = cyc; end
         if (r_ph >= 0) r_ph++;
         if (read_a) begin r_ph = 0; n_read++; t_read = cyc; end
         if (r_ph >= RD_LAT && r_ph < RD_LAT + N) begin
            j = r_ph - RD_LAT;
            i = (j % 2 == 0) ? j / 2 : N / 2 + (j - 1) / 2;
            pe_dout = cap_a[i] ^ cap_b[i];
         end else begin
            pe_dout = 12'hA5C;
            if (r_ph >= RD_LAT + N) r_ph = -1;
         end
      end
      pe_done = (done_mode == 0) ? 1'b1 : ((op_ph == 1) || (op_ph >= 6));
      if (load_a_i || load_b_f || read_b || start_ab) viol++;
      if ((start_fntt || start_pwm2 || start_intt) && (load_a_f || load_b_i || read_a)) viol++;
      if (s_ready && m_valid) viol++;
   end

   task automatic clear_counts();
      n_load_a = 0; n_load_b = 0; n_fntt = 0; n_pwm2 = 0; n_intt = 0; n_read = 0; gap_viol = 0;
   endtask

   task automatic send_words(input int npairs, input bit gaps);
      int sent, budget, p, o;
      sent = 0; budget = 0;
      @(negedge clk);
      while (sent < npairs * 2 * N && budget < npairs * 6000) begin
         p = sent / (2 * N);
         o = sent % (2 * N);
         if (gaps && ($urandom_range(1, 0) == 0)) s_valid = 1'b0;
         else begin
            s_valid = 1'b1;
            s_data  = (o < N) ? va[p][o] : vb[p][o-N];
         end
         if (s_valid && s_ready) sent++;
         @(negedge clk);
         budget++;
      end
      s_valid = 1'b0;
      checks++;
      if (sent !== npairs * 2 * N) begin
         failures++; $display("FAIL send_done: sent %0d words, required %0d", sent, npairs * 2 * N);
      end
   endtask

   task automatic recv_words(input int npairs, input bit bp);
      int got, budget, p, i;
      bit after_last;
      logic [CW-1:0] exp_d;
      got = 0; budget = 0; after_last = 1'b0;
      while (got < npairs * N && budget < npairs * 8000) begin
         @(negedge clk);
         budget++;
         if (after_last) begin
            checks++;
            if (s_ready !== 1'b1) begin failures++; $display("FAIL s_ready_after_last: got %b required 1", s_ready); end
            after_last = 1'b0;
         end
         m_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
         if (m_valid) begin
            p = got / N;
            i = got % N;
            exp_d = va[p][i] ^ vb[p][i];
            checks++;
            if (m_data !== exp_d) begin
               failures++; $display("FAIL m_data[%0d]: got %h required %h", got, m_data, exp_d);
            end
            if (m_ready) begin
               checks++;
               if (m_last !== 1'(i == N - 1)) begin
                  failures++; $display("FAIL m_last[%0d]: got %b required %b", got, m_last, i == N - 1);
               end
               if (i == N - 1) begin
                  checks++;
                  if (s_ready !== 1'b0) begin failures++; $display("FAIL s_ready_on_last: got %b required 0", s_ready); end
                  after_last = 1'b1;
               end
               got++;
            end
         end
      end
      if (after_last) begin
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b1) begin failures++; $display("FAIL s_ready_after_last: got %b required 1", s_ready); end
      end
      m_ready = 1'b0;
      checks++;
      if (got !== npairs * N) begin
         failures++; $display("FAIL recv_done: got %0d words, required %0d", got, npairs * N);
      end
   endtask

   task automatic run_pairs(input int npairs, input bit gaps, input bit bp);
      fork
         send_words(npairs, gaps);
         recv_words(npairs, bp);
      join
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
      checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b required 0", m_last); end
      checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data: got %h required 000", m_data); end
      checks++; if (pe_din !== '0) begin failures++; $display("FAIL reset_pe_din: got %h required 000", pe_din); end
      checks++;
      if ({load_a_f, load_a_i, load_b_f, load_b_i, read_a, read_b, start_ab, start_fntt, start_pwm2, start_intt} !== 10'b0) begin
         failures++; $display("FAIL reset_cmds: got non-zero PE command, required all 0");
      end
   endtask

   task automatic test_pe_order();
      int errs;
      for (int i = 0; i < N; i++) begin
         va[0][i] = 12'((i * 7 + 3) & 12'hFFF);
         vb[0][i] = 12'(i);
      end
      done_mode = 0;
      clear_counts();
      run_pairs(1, 1'b0, 1'b0);
      errs = 0;
      for (int i = 0; i < N; i++) if (cap_a[i] !== va[0][i]) errs++;
      checks++; if (errs !== 0) begin failures++; $display("FAIL a_burst: %0d words wrong, required 0", errs); end
      errs = 0;
      for (int k = 0; k < N; k++) if (raw_b[k] !== 12'(perm(k))) errs++;
      checks++; if (errs !== 0) begin failures++; $display("FAIL b_burst_order: %0d words wrong, required 0", errs); end
      checks++; if (raw_b[1] !== 12'd2) begin failures++; $display("FAIL b_word1: got %0d required 2", raw_b[1]); end
      checks++; if (raw_b[2] !== 12'd1) begin failures++; $display("FAIL b_word2: got %0d required 1", raw_b[2]); end
      checks++; if (raw_b[253] !== 12'd254) begin failures++; $display("FAIL b_word253: got %0d required 254", raw_b[253]); end
      checks++; if (gap_viol !== 0) begin failures++; $display("FAIL pe_din_idle: %0d non-zero idle words, required 0", gap_viol); end
      checks++; if (n_load_a !== 1 || n_load_b !== 1) begin failures++; $display("FAIL load_pulses: got %0d/%0d required 1/1", n_load_a, n_load_b); end
      checks++; if (n_fntt !== 1 || n_pwm2 !== 1 || n_intt !== 1) begin failures++; $display("FAIL op_pulses: got %0d/%0d/%0d required 1/1/1", n_fntt, n_pwm2, n_intt); end
      checks++; if (t_pwm2 - t_fntt !== 4) begin failures++; $display("FAIL fntt_len: got %0d required 4", t_pwm2 - t_fntt); end
      checks++; if (t_intt - t_pwm2 !== 4) begin failures++; $display("FAIL pwm2_len: got %0d required 4", t_intt - t_pwm2); end
      checks++; if (t_read - t_intt !== 6) begin failures++; $display("FAIL intt_to_read: got %0d required 6", t_read - t_intt); end
   endtask

   task automatic test_done_mask();
      for (int i = 0; i < N; i++) begin
         va[0][i] = 12'((i * 37 + 11) & 12'hFFF);
         vb[0][i] = 12'((i * 91 + 500) & 12'hFFF);
      end
      done_mode = 1;
      clear_counts();
      run_pairs(1, 1'b0, 1'b0);
      checks++; if (t_pwm2 - t_fntt !== 7) begin failures++; $display("FAIL masked_fntt_len: got %0d required 7", t_pwm2 - t_fntt); end
      checks++; if (t_intt - t_pwm2 !== 7) begin failures++; $display("FAIL masked_pwm2_len: got %0d required 7", t_intt - t_pwm2); end
      checks++; if (t_read - t_intt !== 9) begin failures++; $display("FAIL masked_intt_to_read: got %0d required 9", t_read - t_intt); end
      done_mode = 0;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) begin
         va[0][i] = 12'((i * 123 + 7) & 12'hFFF);
         vb[0][i] = 12'((4095 - i * 5) & 12'hFFF);
      end
      run_pairs(1, 1'b1, 1'b1);
   endtask

   task automatic test_reset_in_intt();
      int budget;
      for (int i = 0; i < N; i++) begin
         va[0][i] = 12'(i * 3);
         vb[0][i] = 12'(i + 1000);
      end
      done_mode = 1;
      clear_counts();
      send_words(1, 1'b0);
      budget = 0;
      while (n_intt == 0 && budget < 3000) begin @(negedge clk); budget++; end
      checks++; if (n_intt !== 1) begin failures++; $display("FAIL reach_intt: got %0d start_intt pulses required 1", n_intt); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({load_a_f, load_b_i, read_a, start_fntt, start_pwm2, start_intt} !== 6'b0) begin
         failures++; $display("FAIL abort_cmds: got non-zero PE command, required all 0");
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL abort_s_ready: got %b required 1", s_ready); end
      clear_counts();
      repeat (30) @(negedge clk);
      checks++;
      if (n_load_a + n_load_b + n_fntt + n_pwm2 + n_intt + n_read !== 0) begin
         failures++; $display("FAIL abort_quiet: got %0d PE pulses after reset, required 0", n_load_a + n_load_b + n_fntt + n_pwm2 + n_intt + n_read);
      end
      done_mode = 0;
      for (int i = 0; i < N; i++) begin
         va[0][i] = 12'((i * 29 + 1) & 12'hFFF);
         vb[0][i] = 12'((i * 211) & 12'hFFF);
      end
      run_pairs(1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) begin
         va[0][i] = 12'((i * 17 + 2) & 12'hFFF);
         vb[0][i] = 12'((i * 19 + 3) & 12'hFFF);
         va[1][i] = 12'((4095 - i * 13) & 12'hFFF);
         vb[1][i] = 12'((i * 251 + 77) & 12'hFFF);
      end
      run_pairs(2, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_pe_order();
      test_done_mask();
      test_backpressure();
      test_reset_in_intt();
      test_back_to_back();
      checks++;
      if (viol !== 0) begin failures++; $display("FAIL protocol: %0d violations, required 0", viol); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
